// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-side and memory-side signal bundle for icache_assoc
interface icache_assoc_if #(
  parameter int ADDR_W = 30,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 32
);
  localparam int OFF_W = $clog2(WORDS);
  logic                      proc_read;
  logic [ADDR_W-1:0]         proc_addr;
  logic [31:0]               proc_rdata;
  logic                      proc_stall;
  logic                      flush;
  logic                      mem_read;
  logic [ADDR_W-OFF_W-1:0]   mem_addr;
  logic [32*WORDS-1:0]       mem_rdata;
  logic                      mem_ready;
  logic [CNT_W-1:0]          hit_cnt;
  logic [CNT_W-1:0]          miss_cnt;
  modport slave (
    input  proc_read, proc_addr, flush, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr, hit_cnt, miss_cnt
  );
  modport master (
    output proc_read, proc_addr, flush, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative read-only instruction cache with single-outstanding line fill
module icache_assoc #(
  parameter int ADDR_W = 30,
  parameter int WORDS  = 4,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 32
) (
  input logic           clk,
  input logic           proc_reset_n,
  icache_assoc_if.slave bus
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * WORDS;
  typedef enum logic {IDLE, REFILL} state_t;
  state_t                  r_state, w_next;
  logic                    r_valid [WAYS][SETS];
  logic [TAG_W-1:0]        r_tag   [WAYS][SETS];
  logic [LINE_W-1:0]       r_data  [WAYS][SETS];
  logic [WAY_W-1:0]        r_rr    [SETS];
  logic [ADDR_W-OFF_W-1:0] r_mem_addr;
  logic [WAY_W-1:0]        r_victim, w_victim;
  logic                    r_victim_rr, w_victim_rr;
  logic                    r_flush_pend, r_post_fill;
  logic [CNT_W-1:0]        r_hit_cnt, r_miss_cnt;
  logic [OFF_W-1:0]        w_off;
  logic [IDX_W-1:0]        w_idx, w_fidx;
  logic [TAG_W-1:0]        w_tag, w_ftag;
  logic [WAYS-1:0]         w_match;
  logic [31:0]             w_rdata;
  logic                    w_hit, w_launch, w_fill, w_clear;
  assign w_off    = bus.proc_addr[OFF_W-1:0];
  assign w_idx    = bus.proc_addr[OFF_W +: IDX_W];
  assign w_tag    = bus.proc_addr[ADDR_W-1 -: TAG_W];
  assign w_fidx   = r_mem_addr[IDX_W-1:0];
  assign w_ftag   = r_mem_addr[ADDR_W-OFF_W-1 -: TAG_W];
  assign w_hit    = |w_match;
  assign w_launch = r_state == IDLE && bus.proc_read && !w_hit && !bus.flush;
  assign w_fill   = r_state == REFILL && bus.mem_ready;
  // a flush that lands on (or was pending before) fill completion voids the new line too
  assign w_clear  = (r_state == IDLE && bus.flush) || (w_fill && (r_flush_pend || bus.flush));
  // tag compare across ways; matches are one-hot so OR-ing masked words selects the hit word
  always_comb begin
    w_match = '0;
    w_rdata = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_match[w] = r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag;
      w_rdata   |= w_match[w] ? r_data[w][w_idx][32*w_off +: 32] : 32'd0;
    end
  end
  // victim: lowest-numbered invalid way, otherwise the set's round-robin pointer
  always_comb begin
    w_victim    = r_rr[w_idx];
    w_victim_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w][w_idx]) begin
        w_victim    = WAY_W'(w);
        w_victim_rr = 1'b0;
      end
  end
  // FSM state register
  always_ff @(posedge clk or negedge proc_reset_n)
    if (!proc_reset_n) r_state <= IDLE;
    else               r_state <= w_next;
  // FSM next state: leave IDLE on a launched miss, leave REFILL on mem_ready
  always_comb w_next = (r_state == IDLE) ? (w_launch ? REFILL : IDLE) : (bus.mem_ready ? IDLE : REFILL);
  // FSM outputs: mem_read is the REFILL state flop itself, stall is combinational
  always_comb begin
    bus.proc_stall = bus.proc_read && (r_state != IDLE || !w_hit);
    bus.mem_read   = r_state == REFILL;
    bus.mem_addr   = r_mem_addr;
    bus.proc_rdata = w_rdata;
    bus.hit_cnt    = r_hit_cnt;
    bus.miss_cnt   = r_miss_cnt;
  end
  // valid bits and round-robin pointers; the pointer only moves when it chose the victim
  always_ff @(posedge clk or negedge proc_reset_n)
    if (!proc_reset_n) begin
      for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) r_valid[w][s] <= 1'b0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else if (w_clear) begin
      for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) r_valid[w][s] <= 1'b0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else if (w_fill) begin
      r_valid[r_victim][w_fidx] <= 1'b1;
      if (r_victim_rr) r_rr[w_fidx] <= (WAYS > 1) ? r_rr[w_fidx] + 1'b1 : '0;
    end
  // tag and line storage, written only by a completing fill and never reset
  always_ff @(posedge clk)
    if (w_fill) begin
      r_tag[r_victim][w_fidx]  <= w_ftag;
      r_data[r_victim][w_fidx] <= bus.mem_rdata;
    end
  // miss bookkeeping: line address, victim choice, pending flush and post-fill marker
  always_ff @(posedge clk or negedge proc_reset_n)
    if (!proc_reset_n) begin
      r_mem_addr   <= '0;
      r_victim     <= '0;
      r_victim_rr  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_post_fill  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_mem_addr  <= {w_tag, w_idx};
        r_victim    <= w_victim;
        r_victim_rr <= w_victim_rr;
      end
      r_flush_pend <= r_state == REFILL && !w_fill && (r_flush_pend || bus.flush);
      r_post_fill  <= w_fill;
    end
  // saturating hit/miss counters; the hit that consumes a fresh fill is not a hit
  always_ff @(posedge clk or negedge proc_reset_n)
    if (!proc_reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == IDLE && bus.proc_read && w_hit && !r_post_fill && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_launch && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: table-driven scoreboard bench for icache_assoc
module tb_icache_assoc;
  typedef struct {
    logic [29:0] addr;
    int          lat;
    int          stall;
    bit          fmid;
    int          hits;
    int          misses;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  vec_t tv[$];
  always #5 clk = ~clk;
  icache_assoc_if #(.ADDR_W(30), .WORDS(4), .CNT_W(32)) bus();
  icache_assoc_if #(.ADDR_W(30), .WORDS(4), .CNT_W(4))  sat();
  icache_assoc #(.ADDR_W(30), .WORDS(4), .SETS(16), .WAYS(2), .CNT_W(32)) u_dut (
    .clk(clk), .proc_reset_n(rst_n), .bus(bus.slave));
  icache_assoc #(.ADDR_W(30), .WORDS(4), .SETS(16), .WAYS(2), .CNT_W(4)) u_sat (
    .clk(clk), .proc_reset_n(rst_n), .bus(sat.slave));
  assign sat.proc_read = bus.proc_read;
  assign sat.proc_addr = bus.proc_addr;
  assign sat.flush     = bus.flush;
  assign sat.mem_rdata = bus.mem_rdata;
  assign sat.mem_ready = bus.mem_ready;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mw(input logic [27:0] la, input int k);
    return (la == 28'h10) ? 32'h11111111 * 32'(k + 1) : {la[15:0], 8'hA5, 8'(k)};
  endfunction
  function automatic logic [127:0] line(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mw(la, k);
    return l;
  endfunction
  function automatic logic [29:0] mk(input int t, input int i, input int o);
    return {24'(t), 4'(i), 2'(o)};
  endfunction
  function automatic vec_t mkv(input logic [29:0] a, input int l, input int s, input bit f, input int h, input int m);
    vec_t v;
    v.addr = a; v.lat = l; v.stall = s; v.fmid = f; v.hits = h; v.misses = m;
    return v;
  endfunction
  // one fetch: push expected word, act as memory, pop and compare when the stall drops
  task automatic fetch(input logic [29:0] a, input int lat, input int exp_stall, input bit fmid);
    int stall = 0;
    int rc = 0;
    bit fl_done = 0;
    bit done = 0;
    bus.proc_addr = a;
    bus.proc_read = 1'b1;
    exp_q.push_back(mw(a[29:2], int'(a[1:0])));
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus.mem_ready = 1'b0;
      bus.flush = 1'b0;
      #1;
      if (!bus.proc_stall) begin
        chk("rdata", bus.proc_rdata, exp_q.pop_front());
        done = 1;
      end else begin
        stall++;
        if (bus.mem_read) begin
          if (fmid && !fl_done && rc == lat / 2) begin
            bus.flush = 1'b1;
            fl_done = 1;
          end
          if (rc == lat) begin
            chk("mem_addr", bus.mem_addr, a[29:2]);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = line(bus.mem_addr);
          end
          rc++;
        end else rc = 0;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL fetch_timeout: addr %0h still stalled", a);
      void'(exp_q.pop_back());
    end
    chk("stall_cycles", stall, exp_stall);
    @(posedge clk);
    #1 bus.proc_read = 1'b0;
    bus.mem_ready = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
  endtask
  task automatic run(input vec_t v);
    fetch(v.addr, v.lat, v.stall, v.fmid);
    chk("hit_cnt", bus.hit_cnt, v.hits);
    chk("miss_cnt", bus.miss_cnt, v.misses);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.proc_read = 1'b0;
    bus.proc_addr = '0;
    bus.flush = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    // cold miss/hit, then replacement in set 5 (tag3 evicts tag1, tag4 evicts tag2)
    tv.push_back(mkv(30'h41,       3, 5, 0, 0, 1));
    tv.push_back(mkv(30'h42,       0, 0, 0, 1, 1));
    tv.push_back(mkv(mk(1, 5, 0),  1, 3, 0, 1, 2));
    tv.push_back(mkv(mk(2, 5, 1),  2, 4, 0, 1, 3));
    tv.push_back(mkv(mk(1, 5, 2),  0, 0, 0, 2, 3));
    tv.push_back(mkv(mk(3, 5, 3),  0, 2, 0, 2, 4));
    tv.push_back(mkv(mk(2, 5, 0),  0, 0, 0, 3, 4));
    tv.push_back(mkv(mk(4, 5, 0),  1, 3, 0, 3, 5));
    tv.push_back(mkv(mk(3, 5, 1),  0, 0, 0, 4, 5));
    tv.push_back(mkv(mk(1, 5, 0),  0, 2, 0, 4, 6));
    tv.push_back(mkv(mk(4, 5, 2),  0, 0, 0, 5, 6));
    tv.push_back(mkv(mk(2, 5, 0),  0, 2, 0, 5, 7));
    tv.push_back(mkv(mk(1, 5, 3),  0, 0, 0, 6, 7));
    // reset state
    #12;
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_hit_cnt", bus.hit_cnt, 0);
    chk("rst_miss_cnt", bus.miss_cnt, 0);
    chk("rst_stall_idle", bus.proc_stall, 0);
    bus.proc_read = 1'b1;
    #1 chk("rst_stall_read", bus.proc_stall, 1);
    bus.proc_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tv[i]) run(tv[i]);
    // flush in IDLE: everything invalid, refills go way0 then way1
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_hit_cnt", bus.hit_cnt, 6);
    run(mkv(mk(1, 5, 0), 0, 2, 0, 6, 8));
    run(mkv(mk(2, 5, 0), 0, 2, 0, 6, 9));
    run(mkv(mk(1, 5, 1), 0, 0, 0, 7, 9));
    run(mkv(mk(2, 5, 1), 0, 0, 0, 8, 9));
    run(mkv(mk(3, 5, 0), 0, 2, 0, 8, 10));
    run(mkv(mk(2, 5, 0), 0, 0, 0, 9, 10));
    run(mkv(mk(1, 5, 0), 0, 2, 0, 9, 11));
    // flush in the same cycle as a miss: no launch that cycle
    bus.proc_addr = mk(7, 2, 0);
    bus.proc_read = 1'b1;
    bus.flush = 1'b1;
    #1 chk("flush_miss_stall", bus.proc_stall, 1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1 chk("flush_miss_no_launch", bus.mem_read, 0);
    chk("flush_miss_cnt", bus.miss_cnt, 11);
    run(mkv(mk(7, 2, 0), 0, 2, 0, 9, 12));
    // flush during REFILL: the fill is voided and the fetch refills again
    run(mkv(mk(6, 7, 2), 4, 12, 1, 9, 14));
    // counter saturation on the narrow-counter instance
    for (int i = 0; i < 20; i++) fetch(mk(6, 7, i % 4), 0, 0, 0);
    chk("hit_cnt_after20", bus.hit_cnt, 29);
    chk("sat_hit_cnt", sat.hit_cnt, 15);
    chk("sat_miss_cnt", sat.miss_cnt, 14);
    // reset in the middle of a refill
    bus.proc_addr = mk(9, 3, 0);
    bus.proc_read = 1'b1;
    for (int i = 0; i < 10 && !bus.mem_read; i++) @(negedge clk);
    chk("mid_fill_mem_read", bus.mem_read, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_read", bus.mem_read, 0);
    chk("abort_stall", bus.proc_stall, 1);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_hit_cnt", bus.hit_cnt, 0);
    chk("abort_miss_cnt", bus.miss_cnt, 0);
    chk("abort_sat_hit_cnt", sat.hit_cnt, 0);
    bus.proc_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = line(28'h93);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk("late_ready_ignored", bus.mem_read, 0);
    chk("late_ready_miss_cnt", bus.miss_cnt, 0);
    bus.proc_addr = mk(6, 7, 2);
    bus.proc_read = 1'b1;
    #1 chk("post_reset_invalid", bus.proc_stall, 1);
    bus.proc_read = 1'b0;
    @(negedge clk);
    run(mkv(mk(9, 3, 0), 2, 4, 0, 0, 1));
    run(mkv(mk(9, 3, 3), 0, 0, 0, 1, 1));
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
